// File: rtl/sub_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and width limit.
package sub_pkg;
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} sub_state_t;
   localparam int WIDTH_MAX = 32;
endpackage

// File: rtl/full_subtractor.sv
// One-bit combinational full-subtractor cell: d = a - b - bi, bo = borrow out.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bi,
   output logic d,
   output logic bo
);
   assign d  = a ^ b ^ bi;
   assign bo = (~a & b) | (~a & bi) | (b & bi);
endmodule

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial A - B - Bin: one full_subtractor reused over WIDTH clocks, borrow held in a flop.
// Define SUB_OVF_EN to add the signed-overflow output Ovf.
module serial_ripple_subtractor
   import sub_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Diff,
   output logic             Bout
`ifdef SUB_OVF_EN
   ,output logic            Ovf
`endif
);
   localparam int CW = $clog2(WIDTH + 1);

   if (WIDTH < 2 || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("serial_ripple_subtractor: WIDTH out of range");
   end

   sub_state_t       state, state_nxt;
   logic [WIDTH-1:0] a_sr, b_sr;
   logic             borrow;
   logic [CW-1:0]    cnt;
   logic             d, bo;
   logic             last;

   // Counter reaches WIDTH after the last bit; that extra RUN cycle latches Bout/Ovf.
   assign last = (cnt == CW'(WIDTH));

   full_subtractor u_cell (
      .a  (a_sr[0]),
      .b  (b_sr[0]),
      .bi (borrow),
      .d  (d),
      .bo (bo)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (in_valid)  state_nxt = S_RUN;
         S_RUN:   if (last)      state_nxt = S_DONE;
         S_DONE:  if (out_ready) state_nxt = S_IDLE;
         default:                state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == S_IDLE);
      out_valid = (state == S_DONE);
   end

`ifdef SUB_OVF_EN
   logic a_msb, b_msb;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         Ovf   <= 1'b0;
      end else if (state == S_IDLE && in_valid) begin
         a_msb <= A[WIDTH-1];
         b_msb <= B[WIDTH-1];
      end else if (state == S_RUN && last) begin
         Ovf <= (a_msb ^ b_msb) & (Diff[WIDTH-1] ^ a_msb);
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr   <= '0;
         b_sr   <= '0;
         borrow <= 1'b0;
         cnt    <= '0;
         Diff   <= '0;
         Bout   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (in_valid) begin
               a_sr   <= A;
               b_sr   <= B;
               borrow <= Bin;
               cnt    <= '0;
            end
            S_RUN: if (!last) begin
               Diff   <= {d, Diff[WIDTH-1:1]};
               borrow <= bo;
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               cnt    <= cnt + 1'b1;
            end else begin
               Bout   <= borrow;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Self-checking bench for serial_ripple_subtractor (WIDTH=4): vector table, random ops, corner sequences.
module tb_serial_ripple_subtractor;
   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] A = '0, B = '0;
   logic         Bin = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] Diff;
   logic         Bout;
`ifdef SUB_OVF_EN
   logic         Ovf;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   serial_ripple_subtractor #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .Bin(Bin), .out_valid(out_valid), .out_ready(out_ready),
      .Diff(Diff), .Bout(Bout)
`ifdef SUB_OVF_EN
      , .Ovf(Ovf)
`endif
   );

   typedef struct {
      logic [W-1:0] a, b;
      logic         bin;
      logic [W-1:0] diff;
      logic         bout;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operand values.
   function automatic int ref_diff(input int a, input int b, input int bin);
      return (a - b - bin) & ((1 << W) - 1);
   endfunction
   function automatic int ref_bout(input int a, input int b, input int bin);
      return (a < b + bin) ? 1 : 0;
   endfunction
   function automatic int ref_ovf(input int a, input int b, input int bin);
      int sa, sb, r;
      sa = (a >= (1 << (W-1))) ? a - (1 << W) : a;
      sb = (b >= (1 << (W-1))) ? b - (1 << W) : b;
      r  = sa - sb;
      // Formula form: operand signs differ and result sign differs from A.
      return (((a >> (W-1)) ^ (b >> (W-1))) & ((ref_diff(a, b, bin) >> (W-1)) ^ (a >> (W-1)))) & 1
             | ((bin == 0 && (r > (1 << (W-1)) - 1 || r < -(1 << (W-1)))) ? 1 : 0);
   endfunction

   // Present operands, wait for acceptance, then count edges until out_valid.
   task automatic start_op(input int a, input int b, input int bin, output int lat);
      int t;
      @(negedge clk);
      A = W'(a); B = W'(b); Bin = 1'(bin); in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) chk("accept_timeout", 0, 1);
      @(posedge clk); #1 in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
   endtask

   task automatic finish_op();
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
      chk("idle_after_handshake", int'(in_ready), 1);
      chk("valid_drop", int'(out_valid), 0);
   endtask

   task automatic full_op(input string tag, input int a, input int b, input int bin,
                          input int ediff, input int ebout);
      int lat;
      start_op(a, b, bin, lat);
      chk({tag, "_latency"}, lat, W + 1);
      chk({tag, "_diff"}, int'(Diff), ediff);
      chk({tag, "_bout"}, int'(Bout), ebout);
`ifdef SUB_OVF_EN
      chk({tag, "_ovf"}, int'(Ovf), ref_ovf(a, b, bin));
`endif
      finish_op();
   endtask

   vec_t vecs[8];

   initial begin
      int lat, a, b, bin;
      vecs[0] = '{4'd9,  4'd3,  1'b0, 4'd6,  1'b0};
      vecs[1] = '{4'd3,  4'd9,  1'b0, 4'hA,  1'b1};
      vecs[2] = '{4'd0,  4'd0,  1'b1, 4'hF,  1'b1};
      vecs[3] = '{4'd15, 4'd15, 1'b1, 4'hF,  1'b1};
      vecs[4] = '{4'd15, 4'd0,  1'b0, 4'hF,  1'b0};
      vecs[5] = '{4'd8,  4'd1,  1'b0, 4'd7,  1'b0};
      vecs[6] = '{4'd5,  4'd2,  1'b0, 4'd3,  1'b0};
      vecs[7] = '{4'd0,  4'd15, 1'b0, 4'd1,  1'b1};

      #12;
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_diff", int'(Diff), 0);
      chk("rst_bout", int'(Bout), 0);
`ifdef SUB_OVF_EN
      chk("rst_ovf", int'(Ovf), 0);
`endif
      @(negedge clk); rst_n = 1'b1;

      for (int i = 0; i < 8; i++)
         full_op($sformatf("vec%0d", i), int'(vecs[i].a), int'(vecs[i].b), int'(vecs[i].bin),
                 int'(vecs[i].diff), int'(vecs[i].bout));

`ifdef SUB_OVF_EN
      start_op(8, 1, 0, lat);
      chk("ovf_neg8_minus1", int'(Ovf), 1);
      finish_op();
      start_op(5, 2, 0, lat);
      chk("ovf_5_minus2", int'(Ovf), 0);
      finish_op();
`endif

      for (int i = 0; i < 20; i++) begin
         a = int'($urandom_range(0, (1 << W) - 1));
         b = int'($urandom_range(0, (1 << W) - 1));
         bin = int'($urandom_range(0, 1));
         full_op($sformatf("rnd%0d", i), a, b, bin, ref_diff(a, b, bin), ref_bout(a, b, bin));
      end

      // Backpressure: hold DONE with a competing in_valid present.
      start_op(9, 3, 0, lat);
      chk("bp_latency", lat, W + 1);
      @(negedge clk); A = 4'd1; B = 4'd1; Bin = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk($sformatf("bp_valid%0d", i), int'(out_valid), 1);
         chk($sformatf("bp_diff%0d", i), int'(Diff), 6);
         chk($sformatf("bp_bout%0d", i), int'(Bout), 0);
         chk($sformatf("bp_ready%0d", i), int'(in_ready), 0);
      end
      @(negedge clk); in_valid = 1'b0;
      finish_op();

      // Reset mid-RUN: abort, outputs back to reset values at once.
      @(negedge clk); A = 4'd12; B = 4'd1; Bin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      @(posedge clk); @(posedge clk); #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", int'(out_valid), 0);
      chk("mid_rst_diff", int'(Diff), 0);
      chk("mid_rst_in_ready", int'(in_ready), 1);
      chk("mid_rst_bout", int'(Bout), 0);
      @(negedge clk); rst_n = 1'b1;
      full_op("after_rst", 7, 2, 0, 5, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
